// File: rtl/branch_predictor_if.sv
`default_nettype none
// =============================================================================
// Module : branch_predictor_if
// Brief  : Fetch lookup, EX_MEM resolution and statistics bundle of the BTB.
// Rev    : 1.0 - initial release
// =============================================================================
interface branch_predictor_if #(
  parameter int XLEN   = 32,
  parameter int STAT_W = 32
);
  logic [XLEN-1:0]   pc;
  logic              pred_hit;
  logic              pred_taken;
  logic [XLEN-1:0]   pred_target;
  logic [XLEN-1:0]   next_pc;
  logic              upd_valid;
  logic [XLEN-1:0]   upd_pc;
  logic              upd_is_jump;
  logic              upd_taken;
  logic [XLEN-1:0]   upd_target;
  logic              upd_pred_taken;
  logic [XLEN-1:0]   upd_pred_target;
  logic              mispredict;
  logic [XLEN-1:0]   redirect_pc;
  logic [STAT_W-1:0] stat_branches;
  logic [STAT_W-1:0] stat_mispredicts;

  modport master (
    output pc, upd_valid, upd_pc, upd_is_jump, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target,
    input  pred_hit, pred_taken, pred_target, next_pc, mispredict,
           redirect_pc, stat_branches, stat_mispredicts
  );

  modport slave (
    input  pc, upd_valid, upd_pc, upd_is_jump, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target,
    output pred_hit, pred_taken, pred_target, next_pc, mispredict,
           redirect_pc, stat_branches, stat_mispredicts
  );
endinterface
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// =============================================================================
// Module : branch_predictor
// Brief  : Direct-mapped BTB with saturating counters, mispredict detection
//          and saturating branch/mispredict statistics.
// Rev    : 1.0 - initial release
// =============================================================================
module branch_predictor #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int STAT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  branch_predictor_if.slave bp
);
  localparam int               IDX_W    = $clog2(ENTRIES);
  localparam int               TAG_W    = XLEN - IDX_W - 2;
  localparam logic [CTR_W-1:0] CTR_ONE  = CTR_W'(1);
  localparam logic [CTR_W-1:0] CTR_ZERO = '0;
  localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_WT   = CTR_W'(1 << (CTR_W - 1));
  localparam logic [CTR_W-1:0] CTR_WNT  = CTR_WT - CTR_ONE;
  localparam logic [XLEN-1:0]  PC_STEP  = XLEN'(4);
  localparam logic [STAT_W-1:0] STAT_ONE = STAT_W'(1);
  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

  logic [ENTRIES-1:0] valid_q;
  logic [ENTRIES-1:0] jump_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  logic [CTR_W-1:0]   ctr_q    [ENTRIES];
  logic [STAT_W-1:0]  stat_br_q, stat_br_d;
  logic [STAT_W-1:0]  stat_mp_q, stat_mp_d;

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [XLEN-1:0]  lk_pc4;
  logic             lk_hit;
  logic             lk_taken;
  logic [XLEN-1:0]  lk_target;

  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic [XLEN-1:0]  up_pc4;
  logic             up_hit;
  logic             taken_eff;
  logic             mispredict;

  logic             ent_we;
  logic             ent_jump_d;
  logic [XLEN-1:0]  ent_target_d;
  logic [CTR_W-1:0] ent_ctr_d;

  // Instructions are word aligned, so the two low PC bits never select anything.
  logic unused_low_bits;
  assign unused_low_bits = ^{bp.pc[1:0], bp.upd_pc[1:0]};

  assign lk_idx    = bp.pc[IDX_W+1:2];
  assign lk_tag    = bp.pc[XLEN-1:IDX_W+2];
  assign lk_pc4    = bp.pc + PC_STEP;
  assign lk_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lk_taken  = lk_hit && (jump_q[lk_idx] || (ctr_q[lk_idx] >= CTR_WT));
  assign lk_target = lk_hit ? target_q[lk_idx] : lk_pc4;

  assign bp.pred_hit    = lk_hit;
  assign bp.pred_taken  = lk_taken;
  assign bp.pred_target = lk_target;
  assign bp.next_pc     = lk_taken ? lk_target : lk_pc4;

  assign up_idx    = bp.upd_pc[IDX_W+1:2];
  assign up_tag    = bp.upd_pc[XLEN-1:IDX_W+2];
  assign up_pc4    = bp.upd_pc + PC_STEP;
  assign up_hit    = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign taken_eff = bp.upd_is_jump || bp.upd_taken;

  assign mispredict = bp.upd_valid &&
                      ((bp.upd_pred_taken != taken_eff) ||
                       (taken_eff && (bp.upd_pred_target != bp.upd_target)));

  assign bp.mispredict       = mispredict;
  assign bp.redirect_pc      = taken_eff ? bp.upd_target : up_pc4;
  assign bp.stat_branches    = stat_br_q;
  assign bp.stat_mispredicts = stat_mp_q;

  // Next contents of the single entry addressed by the resolving instruction.
  always_comb begin
    ent_we       = 1'b0;
    ent_jump_d   = jump_q[up_idx];
    ent_target_d = target_q[up_idx];
    ent_ctr_d    = ctr_q[up_idx];
    if (bp.upd_valid) begin
      if (up_hit) begin
        ent_we = 1'b1;
        if (bp.upd_is_jump) begin
          ent_jump_d   = 1'b1;
          ent_target_d = bp.upd_target;
          ent_ctr_d    = CTR_MAX;
        end else begin
          ent_jump_d = 1'b0;
          if (bp.upd_taken) begin
            ent_target_d = bp.upd_target;
            if (ctr_q[up_idx] != CTR_MAX) begin
              ent_ctr_d = ctr_q[up_idx] + CTR_ONE;
            end
          end else if (ctr_q[up_idx] != CTR_ZERO) begin
            ent_ctr_d = ctr_q[up_idx] - CTR_ONE;
          end
        end
      end else if (taken_eff) begin
        ent_we       = 1'b1;
        ent_jump_d   = bp.upd_is_jump;
        ent_target_d = bp.upd_target;
        ent_ctr_d    = bp.upd_is_jump ? CTR_MAX : CTR_WT;
      end
    end
  end

  always_comb begin
    stat_br_d = stat_br_q;
    stat_mp_d = stat_mp_q;
    if (bp.upd_valid && (stat_br_q != STAT_MAX)) begin
      stat_br_d = stat_br_q + STAT_ONE;
    end
    if (mispredict && (stat_mp_q != STAT_MAX)) begin
      stat_mp_d = stat_mp_q + STAT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= '0;
      jump_q    <= '0;
      stat_br_q <= '0;
      stat_mp_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WNT;
      end
    end else begin
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
      if (ent_we) begin
        valid_q[up_idx]  <= 1'b1;
        jump_q[up_idx]   <= ent_jump_d;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= ent_target_d;
        ctr_q[up_idx]    <= ent_ctr_d;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// =============================================================================
// Module : tb_branch_predictor
// Brief  : Directed self-checking bench for branch_predictor (16 entries, 2-bit ctr).
// Rev    : 1.0 - initial release
// =============================================================================
module tb_branch_predictor;
  localparam int XLEN   = 32;
  localparam int STAT_W = 32;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  branch_predictor_if #(.XLEN(XLEN), .STAT_W(STAT_W)) bp_if ();

  branch_predictor #(
    .XLEN(XLEN), .ENTRIES(16), .CTR_W(2), .STAT_W(STAT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bp (bp_if)
  );

  always #5 clk = ~clk;

  // Drive one resolved update in the low clock phase; it commits on the next rising edge.
  task automatic set_upd(input logic [31:0] pc, input logic jump, input logic taken,
                         input logic [31:0] target, input logic ptaken,
                         input logic [31:0] ptarget);
    @(negedge clk);
    bp_if.upd_valid       = 1'b1;
    bp_if.upd_pc          = pc;
    bp_if.upd_is_jump     = jump;
    bp_if.upd_taken       = taken;
    bp_if.upd_target      = target;
    bp_if.upd_pred_taken  = ptaken;
    bp_if.upd_pred_target = ptarget;
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    bp_if.upd_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bp_if.pc = 32'd100;
    bp_if.upd_valid = 1'b0; bp_if.upd_pc = '0; bp_if.upd_is_jump = 1'b0;
    bp_if.upd_taken = 1'b0; bp_if.upd_target = '0;
    bp_if.upd_pred_taken = 1'b0; bp_if.upd_pred_target = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bp_if.pred_hit !== 1'b0) begin errors++; $display("FAIL reset_hit: got %h expected 0", bp_if.pred_hit); end
    checks++; if (bp_if.pred_taken !== 1'b0) begin errors++; $display("FAIL reset_taken: got %h expected 0", bp_if.pred_taken); end
    checks++; if (bp_if.next_pc !== 32'd104) begin errors++; $display("FAIL reset_next_pc: got %0d expected 104", bp_if.next_pc); end
    checks++; if (bp_if.pred_target !== 32'd104) begin errors++; $display("FAIL reset_target: got %0d expected 104", bp_if.pred_target); end
    checks++; if (bp_if.stat_branches !== 32'd0) begin errors++; $display("FAIL reset_stat_br: got %0d expected 0", bp_if.stat_branches); end
    checks++; if (bp_if.stat_mispredicts !== 32'd0) begin errors++; $display("FAIL reset_stat_mp: got %0d expected 0", bp_if.stat_mispredicts); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_train_taken();
    bp_if.pc = 32'd100;
    set_upd(32'd100, 1'b0, 1'b1, 32'd80, 1'b0, 32'd104);
    checks++; if (bp_if.mispredict !== 1'b1) begin errors++; $display("FAIL train_mispredict: got %h expected 1", bp_if.mispredict); end
    checks++; if (bp_if.redirect_pc !== 32'd80) begin errors++; $display("FAIL train_redirect: got %0d expected 80", bp_if.redirect_pc); end
    checks++; if (bp_if.pred_hit !== 1'b0) begin errors++; $display("FAIL train_no_bypass: got %h expected 0", bp_if.pred_hit); end
    idle();
    checks++; if (bp_if.pred_hit !== 1'b1) begin errors++; $display("FAIL train_hit: got %h expected 1", bp_if.pred_hit); end
    checks++; if (bp_if.pred_taken !== 1'b1) begin errors++; $display("FAIL train_taken: got %h expected 1", bp_if.pred_taken); end
    checks++; if (bp_if.next_pc !== 32'd80) begin errors++; $display("FAIL train_next_pc: got %0d expected 80", bp_if.next_pc); end
    checks++; if (bp_if.stat_branches !== 32'd1) begin errors++; $display("FAIL train_stat_br: got %0d expected 1", bp_if.stat_branches); end
    checks++; if (bp_if.stat_mispredicts !== 32'd1) begin errors++; $display("FAIL train_stat_mp: got %0d expected 1", bp_if.stat_mispredicts); end
  endtask

  task automatic test_counter();
    bp_if.pc = 32'd100;
    set_upd(32'd100, 1'b0, 1'b0, 32'd0, 1'b1, 32'd80);          // ctr 2 -> 1
    checks++; if (bp_if.mispredict !== 1'b1) begin errors++; $display("FAIL nt1_mispredict: got %h expected 1", bp_if.mispredict); end
    checks++; if (bp_if.redirect_pc !== 32'd104) begin errors++; $display("FAIL nt1_redirect: got %0d expected 104", bp_if.redirect_pc); end
    idle();
    checks++; if (bp_if.pred_taken !== 1'b0) begin errors++; $display("FAIL nt1_taken: got %h expected 0", bp_if.pred_taken); end
    checks++; if (bp_if.pred_target !== 32'd80) begin errors++; $display("FAIL nt1_target_kept: got %0d expected 80", bp_if.pred_target); end
    checks++; if (bp_if.next_pc !== 32'd104) begin errors++; $display("FAIL nt1_next_pc: got %0d expected 104", bp_if.next_pc); end
    set_upd(32'd100, 1'b0, 1'b0, 32'd0, 1'b0, 32'd104);         // ctr 1 -> 0
    checks++; if (bp_if.mispredict !== 1'b0) begin errors++; $display("FAIL nt2_mispredict: got %h expected 0", bp_if.mispredict); end
    set_upd(32'd100, 1'b0, 1'b0, 32'd0, 1'b0, 32'd104);         // ctr stays 0
    set_upd(32'd100, 1'b0, 1'b1, 32'd80, 1'b0, 32'd104);        // ctr 0 -> 1
    idle();
    checks++; if (bp_if.pred_taken !== 1'b0) begin errors++; $display("FAIL sat_low_taken: got %h expected 0", bp_if.pred_taken); end
    set_upd(32'd100, 1'b0, 1'b1, 32'd80, 1'b0, 32'd104);        // ctr 1 -> 2
    idle();
    checks++; if (bp_if.pred_taken !== 1'b1) begin errors++; $display("FAIL relearn_taken: got %h expected 1", bp_if.pred_taken); end
    set_upd(32'd100, 1'b0, 1'b1, 32'h90, 1'b1, 32'd80);         // ctr 3, wrong target
    checks++; if (bp_if.mispredict !== 1'b1) begin errors++; $display("FAIL tgt_mispredict: got %h expected 1", bp_if.mispredict); end
    checks++; if (bp_if.redirect_pc !== 32'h90) begin errors++; $display("FAIL tgt_redirect: got %h expected 90", bp_if.redirect_pc); end
    set_upd(32'd100, 1'b0, 1'b1, 32'h90, 1'b1, 32'h90);         // ctr stays 3
    checks++; if (bp_if.mispredict !== 1'b0) begin errors++; $display("FAIL tgt_ok_mispredict: got %h expected 0", bp_if.mispredict); end
    set_upd(32'd100, 1'b0, 1'b0, 32'd0, 1'b1, 32'h90);          // ctr 3 -> 2
    idle();
    checks++; if (bp_if.next_pc !== 32'h90) begin errors++; $display("FAIL sat_high_next_pc: got %h expected 90", bp_if.next_pc); end
    checks++; if (bp_if.stat_branches !== 32'd9) begin errors++; $display("FAIL ctr_stat_br: got %0d expected 9", bp_if.stat_branches); end
    checks++; if (bp_if.stat_mispredicts !== 32'd6) begin errors++; $display("FAIL ctr_stat_mp: got %0d expected 6", bp_if.stat_mispredicts); end
  endtask

  task automatic test_jump();
    bp_if.pc = 32'd200;
    set_upd(32'd200, 1'b1, 1'b0, 32'h1000, 1'b0, 32'd204);
    checks++; if (bp_if.mispredict !== 1'b1) begin errors++; $display("FAIL jump_mispredict: got %h expected 1", bp_if.mispredict); end
    checks++; if (bp_if.redirect_pc !== 32'h1000) begin errors++; $display("FAIL jump_redirect: got %h expected 1000", bp_if.redirect_pc); end
    idle();
    checks++; if (bp_if.pred_taken !== 1'b1) begin errors++; $display("FAIL jump_taken: got %h expected 1", bp_if.pred_taken); end
    checks++; if (bp_if.next_pc !== 32'h1000) begin errors++; $display("FAIL jump_next_pc: got %h expected 1000", bp_if.next_pc); end
  endtask

  task automatic test_alias();
    set_upd(32'h40, 1'b0, 1'b1, 32'h300, 1'b0, 32'h44);
    idle();
    bp_if.pc = 32'h40; #1;
    checks++; if (bp_if.next_pc !== 32'h300) begin errors++; $display("FAIL alias_train_next_pc: got %h expected 300", bp_if.next_pc); end
    bp_if.pc = 32'h80; #1;
    checks++; if (bp_if.pred_hit !== 1'b0) begin errors++; $display("FAIL alias_tag_miss: got %h expected 0", bp_if.pred_hit); end
    checks++; if (bp_if.next_pc !== 32'h84) begin errors++; $display("FAIL alias_miss_next_pc: got %h expected 84", bp_if.next_pc); end
    set_upd(32'h80, 1'b0, 1'b0, 32'h0, 1'b0, 32'h84);           // no allocation
    checks++; if (bp_if.mispredict !== 1'b0) begin errors++; $display("FAIL alias_nt_mispredict: got %h expected 0", bp_if.mispredict); end
    idle();
    bp_if.pc = 32'h40; #1;
    checks++; if (bp_if.pred_hit !== 1'b1) begin errors++; $display("FAIL alias_nt_keeps: got %h expected 1", bp_if.pred_hit); end
    set_upd(32'h80, 1'b0, 1'b1, 32'h500, 1'b0, 32'h84);
    idle();
    bp_if.pc = 32'h80; #1;
    checks++; if (bp_if.next_pc !== 32'h500) begin errors++; $display("FAIL alias_replace_next_pc: got %h expected 500", bp_if.next_pc); end
    bp_if.pc = 32'h40; #1;
    checks++; if (bp_if.pred_hit !== 1'b0) begin errors++; $display("FAIL alias_evicted: got %h expected 0", bp_if.pred_hit); end
    checks++; if (bp_if.next_pc !== 32'h44) begin errors++; $display("FAIL alias_evicted_next_pc: got %h expected 44", bp_if.next_pc); end
    checks++; if (bp_if.stat_branches !== 32'd13) begin errors++; $display("FAIL alias_stat_br: got %0d expected 13", bp_if.stat_branches); end
    checks++; if (bp_if.stat_mispredicts !== 32'd9) begin errors++; $display("FAIL alias_stat_mp: got %0d expected 9", bp_if.stat_mispredicts); end
  endtask

  task automatic test_same_cycle();
    bp_if.pc = 32'd100;
    set_upd(32'd100, 1'b0, 1'b0, 32'd0, 1'b1, 32'h90);          // ctr 2 -> 1
    checks++; if (bp_if.pred_taken !== 1'b1) begin errors++; $display("FAIL same_cycle_old_taken: got %h expected 1", bp_if.pred_taken); end
    checks++; if (bp_if.next_pc !== 32'h90) begin errors++; $display("FAIL same_cycle_old_next_pc: got %h expected 90", bp_if.next_pc); end
    idle();
    checks++; if (bp_if.pred_taken !== 1'b0) begin errors++; $display("FAIL same_cycle_new_taken: got %h expected 0", bp_if.pred_taken); end
    checks++; if (bp_if.next_pc !== 32'd104) begin errors++; $display("FAIL same_cycle_new_next_pc: got %0d expected 104", bp_if.next_pc); end
  endtask

  task automatic test_wrap();
    bp_if.pc = 32'hFFFF_FFFC; #1;
    checks++; if (bp_if.next_pc !== 32'h0) begin errors++; $display("FAIL wrap_next_pc: got %h expected 0", bp_if.next_pc); end
    set_upd(32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (bp_if.redirect_pc !== 32'h0) begin errors++; $display("FAIL wrap_redirect: got %h expected 0", bp_if.redirect_pc); end
    idle();
    checks++; if (bp_if.stat_branches !== 32'd15) begin errors++; $display("FAIL wrap_stat_br: got %0d expected 15", bp_if.stat_branches); end
    checks++; if (bp_if.stat_mispredicts !== 32'd10) begin errors++; $display("FAIL wrap_stat_mp: got %0d expected 10", bp_if.stat_mispredicts); end
  endtask

  task automatic test_reset_mid();
    bp_if.pc = 32'd200; #1;
    checks++; if (bp_if.pred_hit !== 1'b1) begin errors++; $display("FAIL pre_reset_hit: got %h expected 1", bp_if.pred_hit); end
    set_upd(32'd100, 1'b0, 1'b1, 32'h700, 1'b0, 32'd104);
    rst = 1'b1; #1;
    checks++; if (bp_if.pred_hit !== 1'b0) begin errors++; $display("FAIL async_reset_hit: got %h expected 0", bp_if.pred_hit); end
    checks++; if (bp_if.stat_branches !== 32'd0) begin errors++; $display("FAIL async_reset_stat: got %0d expected 0", bp_if.stat_branches); end
    @(negedge clk);
    rst = 1'b0;
    bp_if.upd_valid = 1'b0;
    bp_if.pc = 32'd100; #1;
    checks++; if (bp_if.pred_hit !== 1'b0) begin errors++; $display("FAIL reset_blocks_write: got %h expected 0", bp_if.pred_hit); end
    checks++; if (bp_if.next_pc !== 32'd104) begin errors++; $display("FAIL reset_blocks_next_pc: got %0d expected 104", bp_if.next_pc); end
    checks++; if (bp_if.stat_mispredicts !== 32'd0) begin errors++; $display("FAIL reset_mid_stat_mp: got %0d expected 0", bp_if.stat_mispredicts); end
  endtask

  initial begin
    test_reset();
    test_train_taken();
    test_counter();
    test_jump();
    test_alias();
    test_same_cycle();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
